exp_sum_accumulator: RTL and testbench
======================================

# exp_sum_accumulator

- Streaming reduction stage between the pow2 approximation and `log2_approx` in the softmax datapath.
- Accepts one vector of Q4.12 exponent terms, one element per handshake, and accumulates them in a widened register.
- Emits the saturated Q4.12 sum, the element count and status flags as a single held result. The sum is the `in_x` operand of `log2_approx`.

## Interface

- `DATA_W`, 16: element and sum width (Q4.12).
- `MAX_LEN`, 64: maximum elements per vector. Must be a power of two and at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input element valid.
- `in_ready`  out  1  block can accept an element.
- `in_data`  in  DATA_W  signed Q4.12 element.
- `in_last`  in  1  marks the final element of the vector.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  DATA_W  saturated Q4.12 sum.
- `out_count`  out  $clog2(MAX_LEN)+1  elements accumulated.
- `out_sat`  out  1  the true sum exceeded 0x7FFF.
- `out_trunc`  out  1  the vector was closed at MAX_LEN without `in_last`.

## Operation

**States**
- ACCUM: `in_ready`=1, `out_valid`=0.
- HOLD: `in_ready`=0, `out_valid`=1.

**Input transfer** (`in_valid` && `in_ready`)
- `in_data` is clamped: a negative value (bit 15 set) becomes 0.
- The clamped value is added to the accumulator, which is unsigned, DATA_W+$clog2(MAX_LEN) bits wide (22 by default), and cannot overflow.
- The count increments.

**End of vector**
- A transfer ends the vector if `in_last`=1, or if it is the MAX_LEN-th element.
- On that transfer, register the results and go to HOLD:
  - `out_sum` = min(acc_next, 0x7FFF).
  - `out_sat` = (acc_next > 0x7FFF).
  - `out_count` = count_next.
  - `out_trunc` = (count_next == MAX_LEN && !`in_last`).
- If `in_last`=1 on exactly the MAX_LEN-th element, `out_trunc`=0.

**Result transfer** (`out_valid` && `out_ready` in HOLD)
- Clear the accumulator and count, and return to ACCUM.
- All result outputs keep their values until the next vector completes.

**Other rules**
- `in_data` and `in_last` are ignored while `in_valid`=0.
- ACCUM with no transfers holds state indefinitely.
- Reset at any time, including mid-vector or in HOLD:
  - State goes to ACCUM; accumulator and count clear.
  - `out_valid`=0, `out_sum`=0, `out_count`=0, `out_sat`=0, `out_trunc`=0.
  - `in_ready`=1 once reset deasserts.

## Timing

- `in_ready` and `out_valid` are decoded from the state register, so they are registered.
- There is no combinational path from any input to any output.
- Latency: `out_valid` rises on the edge that completes the last-element transfer and is visible the cycle after it was presented.
- `in_ready` returns to 1 in the cycle after the result handshake. There is no bypass.
- Minimum period per vector: N+1 cycles with `out_ready` held high.
- While `out_valid`=1 and `out_ready`=0, every output is stable.
- No input transfer can coincide with an output transfer, because `in_ready`=0 in HOLD.

## Configuration

- `EXP_SUM_ZERO_GUARD_EN` defined:
  - If the saturated sum would be 0x0000, `out_sum` is forced to 0x0001, the smallest positive Q4.12 value.
  - This keeps `log2_approx` away from log2(0).
  - `out_sat` is unaffected.
- Undefined: `out_sum` = 0x0000 for an all-zero or all-negative vector.

## Test plan

- **Basic sum:** 4 × 0x1000, last on the 4th, `out_ready`=1 → `out_sum`=0x4000, `out_count`=4, `out_sat`=0, `out_trunc`=0; `in_ready` back to 1 two cycles after the last beat.
- **Saturation:** 8 × 0x1000 with last → `out_sum`=0x7FFF, `out_sat`=1, `out_count`=8.
- **Negative clamp / zero guard:**
  - 0xF000 then 0x0800 with last → `out_sum`=0x0800, `out_count`=2.
  - Single 0x0000 with last → `out_sum`=0x0001 with `EXP_SUM_ZERO_GUARD_EN` defined, 0x0000 without.
- **Truncation:**
  - 64 × 0x0040, no last → `out_sum`=0x1000, `out_count`=64, `out_trunc`=1.
  - Repeat with last on beat 64 → `out_trunc`=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after completion → `out_valid`=1 and all outputs stable, `in_ready`=0, and `in_valid` pulses are not accepted. Then `out_ready`=1 for one cycle → `out_valid`=0 next cycle.
- **Reset mid-operation:**
  - Assert `rst` after 3 of 5 elements → all outputs 0 and `in_ready`=1.
  - A new vector 2 × 0x0800 with last → `out_sum`=0x1000, `out_count`=2.

Source files
------------

// File: rtl/exp_sum_accumulator.sv
// exp_sum_accumulator
//   Streaming reduction stage of the softmax datapath. Accepts one vector of
//   signed Q4.12 exponent terms (one element per handshake), clamps negative
//   terms to zero, sums them in a widened unsigned accumulator, and presents
//   the saturated Q4.12 sum, element count and status flags as a held result.
//
// Optional build macro: EXP_SUM_ZERO_GUARD_EN
//   When defined, a result sum of 0x0000 is replaced by 0x0001 so that the
//   downstream log2 stage never sees zero. out_sat is unaffected.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input element valid
//   in_ready   block can accept an element (high in ACCUM)
//   in_data    signed Q4.12 element
//   in_last    final element of the vector
//   out_valid  result valid (high in HOLD)
//   out_ready  downstream accepts the result
//   out_sum    saturated Q4.12 sum
//   out_count  number of elements accumulated
//   out_sat    true sum exceeded the Q4.12 maximum
//   out_trunc  vector closed at MAX_LEN without in_last
//
// Handshake: a transfer occurs on a rising edge where valid and ready are both
// high. Both ready and valid are decoded from the state register, so no input
// reaches any output combinationally. Input and output transfers can never
// coincide because in_ready is low whenever out_valid is high.

module exp_sum_accumulator #(
    parameter int DATA_W  = 16,
    parameter int MAX_LEN = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_sum,
    output logic [$clog2(MAX_LEN):0]    out_count,
    output logic                        out_sat,
    output logic                        out_trunc
);

    localparam int LEN_W = $clog2(MAX_LEN);
    localparam int CNT_W = LEN_W + 1;
    localparam int ACC_W = DATA_W + LEN_W;

    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_LEN);
    localparam logic [DATA_W-1:0] SUM_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  SAT_LIMIT = {{LEN_W{1'b0}}, SUM_MAX};

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]  res_count_q, res_count_d;
    logic              sat_q, sat_d;
    logic              trunc_q, trunc_d;

    logic              in_xfer;
    logic [DATA_W-1:0] in_clamped;
    logic [ACC_W-1:0]  acc_next;
    logic [CNT_W-1:0]  count_next;
    logic              end_vec;
    logic              sat_next;
    logic [DATA_W-1:0] sum_next;

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign out_sum   = sum_q;
    assign out_count = res_count_q;
    assign out_sat   = sat_q;
    assign out_trunc = trunc_q;

    assign in_xfer    = in_valid && in_ready;
    // Exponent terms are nonnegative by construction; a negative value is an
    // upstream artefact and contributes nothing.
    assign in_clamped = in_data[DATA_W-1] ? '0 : in_data;
    // LEN_W guard bits cover MAX_LEN maximal terms, so this never wraps.
    assign acc_next   = acc_q + {{LEN_W{1'b0}}, in_clamped};
    assign count_next = count_q + CNT_W'(1);
    assign end_vec    = in_last || (count_next == MAX_CNT);
    assign sat_next   = (acc_next > SAT_LIMIT);

    always_comb begin
        sum_next = sat_next ? SUM_MAX : acc_next[DATA_W-1:0];
`ifdef EXP_SUM_ZERO_GUARD_EN
        // Smallest positive Q4.12 value keeps log2 of the sum finite.
        if (sum_next == '0) begin
            sum_next = {{(DATA_W-1){1'b0}}, 1'b1};
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sum_d       = sum_q;
        res_count_d = res_count_q;
        sat_d       = sat_q;
        trunc_d     = trunc_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_xfer) begin
                    acc_d   = acc_next;
                    count_d = count_next;
                    if (end_vec) begin
                        sum_d       = sum_next;
                        res_count_d = count_next;
                        sat_d       = sat_next;
                        trunc_d     = (count_next == MAX_CNT) && !in_last;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Result registers stay as they are until the next vector
                // closes; only the running accumulation is cleared here.
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            res_count_q <= '0;
            sat_q       <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            res_count_q <= res_count_d;
            sat_q       <= sat_d;
            trunc_q     <= trunc_d;
        end
    end

endmodule

// File: tb/tb_exp_sum_accumulator.sv
// Testbench for exp_sum_accumulator: table of directed vectors plus
// hand-written backpressure and mid-vector reset sequences.
module tb_exp_sum_accumulator;

  localparam int DATA_W  = 16;
  localparam int MAX_LEN = 64;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

`ifdef EXP_SUM_ZERO_GUARD_EN
  localparam logic [15:0] ZERO_SUM = 16'h0001;
`else
  localparam logic [15:0] ZERO_SUM = 16'h0000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data  = '0;
  logic              in_last  = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;
  logic              out_trunc;

  exp_sum_accumulator #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_sat(out_sat), .out_trunc(out_trunc)
  );

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for in_ready; an expired bound counts as a failure.
  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // Idle gap with garbage on data/last, which must be ignored.
  task automatic idle_gap(input int cycles);
    for (int g = 0; g < cycles; g++) begin
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom);
      tick();
    end
    in_last = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [15:0] s, input int c,
                            input logic sat, input logic trunc);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    chk({tag, "_sum"},       {16'd0, out_sum},   {16'd0, s});
    chk({tag, "_count"},     32'(out_count),     32'(c));
    chk({tag, "_sat"},       {31'd0, out_sat},   {31'd0, sat});
    chk({tag, "_trunc"},     {31'd0, out_trunc}, {31'd0, trunc});
  endtask

  // Accept the held result and check the state the cycle after.
  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rel_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rel_in_ready"},  {31'd0, in_ready},  32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    int          n;
    logic [15:0] d0;     // first element
    logic [15:0] d;      // remaining elements
    logic        last;   // assert in_last on the final element
    logic [15:0] e_sum;
    int          e_count;
    logic        e_sat;
    logic        e_trunc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"basic",      4, 16'h1000, 16'h1000, 1'b1, 16'h4000,  4, 1'b0, 1'b0};
    vecs[1] = '{"sat8",       8, 16'h1000, 16'h1000, 1'b1, 16'h7FFF,  8, 1'b1, 1'b0};
    vecs[2] = '{"neg_clamp",  2, 16'hF000, 16'h0800, 1'b1, 16'h0800,  2, 1'b0, 1'b0};
    vecs[3] = '{"zero_one",   1, 16'h0000, 16'h0000, 1'b1, ZERO_SUM,  1, 1'b0, 1'b0};
    vecs[4] = '{"trunc64",   64, 16'h0040, 16'h0040, 1'b0, 16'h1000, 64, 1'b0, 1'b1};
    vecs[5] = '{"last64",    64, 16'h0040, 16'h0040, 1'b1, 16'h1000, 64, 1'b0, 1'b0};
    vecs[6] = '{"max3",       3, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF,  3, 1'b1, 1'b0};
    vecs[7] = '{"all_neg",    2, 16'h8000, 16'hFFFF, 1'b1, ZERO_SUM,  2, 1'b0, 1'b0};
    vecs[8] = '{"exact_max",  2, 16'h7000, 16'h0FFF, 1'b1, 16'h7FFF,  2, 1'b0, 1'b0};
  end

  // ---------------- main sequence ----------------
  initial begin
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_sum",       {16'd0, out_sum},   32'd0);
    chk("rst_count",     32'(out_count),     32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      wait_ready();
      for (int k = 0; k < vecs[v].n; k++) begin
        idle_gap($urandom_range(0, 2));
        chk({vecs[v].name, "_pending"}, {31'd0, out_valid}, 32'd0);
        beat((k == 0) ? vecs[v].d0 : vecs[v].d, vecs[v].last && (k == vecs[v].n - 1));
      end
      chk_result(vecs[v].name, vecs[v].e_sum, vecs[v].e_count, vecs[v].e_sat, vecs[v].e_trunc);
      release_result(vecs[v].name);
    end

    // Backpressure: result held stable, input pulses ignored.
    wait_ready();
    beat(16'h0200, 1'b0);
    beat(16'h0200, 1'b0);
    beat(16'h0200, 1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 16'h1111;
      in_last  = 1'b1;
      chk_result("bp", 16'h0600, 3, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_result("bp_end", 16'h0600, 3, 1'b0, 1'b0);
    release_result("bp");
    chk("bp_held_sum", {16'd0, out_sum}, 32'h0600);
    beat(16'h0100, 1'b1);
    chk_result("bp_next", 16'h0100, 1, 1'b0, 1'b0);
    release_result("bp_next");

    // Reset after 3 of 5 elements.
    beat(16'h0100, 1'b0);
    beat(16'h0100, 1'b0);
    beat(16'h0100, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum",       {16'd0, out_sum},   32'd0);
    chk("mid_rst_count",     32'(out_count),     32'd0);
    chk("mid_rst_sat",       {31'd0, out_sat},   32'd0);
    chk("mid_rst_trunc",     {31'd0, out_trunc}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    beat(16'h0800, 1'b0);
    beat(16'h0800, 1'b1);
    chk_result("post_rst", 16'h1000, 2, 1'b0, 1'b0);
    release_result("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
